// File: rtl/freq_sel_sched_if.sv
// Control/status bundle between a scan controller and freq_sel_sched.
// The master drives table writes and run commands; the slave returns the
// selector bin index plus scan status.
interface freq_sel_sched_if #(
  parameter int N_ENTRY     = 16,
  parameter int K_WIDTH     = 14,
  parameter int DWELL_WIDTH = 16
);
  localparam int AW = $clog2(N_ENTRY);

  logic                   cfg_we;
  logic [AW-1:0]          cfg_addr;
  logic [K_WIDTH-1:0]     cfg_k;
  logic [AW:0]            cfg_len;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic                   start;
  logic                   stop;
  logic                   frame_sync;

  logic [K_WIDTH-1:0]     k_out;
  logic                   k_upd;
  logic                   gate;
  logic [AW-1:0]          entry_idx;
  logic                   busy;
  logic                   err;

  modport master (
    output cfg_we, cfg_addr, cfg_k, cfg_len, cfg_dwell, start, stop, frame_sync,
    input  k_out, k_upd, gate, entry_idx, busy, err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_k, cfg_len, cfg_dwell, start, stop, frame_sync,
    output k_out, k_upd, gate, entry_idx, busy, err
  );
endinterface

// File: rtl/freq_sel_sched.sv
// Frequency-bin scan scheduler. Steps through a programmable table of bin
// indices, holding each entry for one settle frame (gate low) followed by
// `dwell` gated frames, all paced by the upstream frame_sync pulse.
module freq_sel_sched #(
  parameter int N_ENTRY     = 16,
  parameter int K_WIDTH     = 14,
  parameter int DWELL_WIDTH = 16
) (
  input logic              clk,
  input logic              reset,
  freq_sel_sched_if.slave  bus
);
  localparam int AW = $clog2(N_ENTRY);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, ARM, SETTLE, DWELL} state_t;

  state_t                 state_q, state_d;
  logic [K_WIDTH-1:0]     tbl [N_ENTRY];
  logic [K_WIDTH-1:0]     k_q, k_d;
  logic                   upd_q, upd_d;
  logic                   gate_q, gate_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic                   err_q, err_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [LW-1:0]          len_q, len_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;

  logic [AW-1:0]          nxt_idx;
  logic [DWELL_WIDTH-1:0] cnt_inc;

  // Wrap back to entry 0 after the last active entry.
  assign nxt_idx = (({1'b0, idx_q} + LW'(1)) == len_q) ? '0 : idx_q + AW'(1);
  assign cnt_inc = cnt_q + DWELL_WIDTH'(1);

  // Bin table: writable in any state, deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (bus.cfg_we) tbl[bus.cfg_addr] <= bus.cfg_k;
  end

  // Next-state and next-output logic; stop overrides everything except reset.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    upd_d   = 1'b0;
    gate_d  = gate_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    len_d   = len_q;
    dwell_d = dwell_q;
    if (bus.stop) begin
      state_d = IDLE;
      gate_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.cfg_len == '0) begin
              err_d = 1'b1;
            end else begin
              state_d = ARM;
              len_d   = bus.cfg_len;
              dwell_d = (bus.cfg_dwell == '0) ? DWELL_WIDTH'(1) : bus.cfg_dwell;
            end
          end
        end
        ARM: begin
          if (bus.frame_sync) begin
            state_d = SETTLE;
            idx_d   = '0;
            k_d     = tbl[0];
            upd_d   = 1'b1;
            gate_d  = 1'b0;
          end
        end
        SETTLE: begin
          if (bus.frame_sync) begin
            state_d = DWELL;
            gate_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        DWELL: begin
          if (bus.frame_sync) begin
            if (cnt_inc == dwell_q) begin
              state_d = SETTLE;
              idx_d   = nxt_idx;
              k_d     = tbl[nxt_idx];
              upd_d   = 1'b1;
              gate_d  = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      upd_q   <= 1'b0;
      gate_q  <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      upd_q   <= upd_d;
      gate_q  <= gate_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dwell_q <= dwell_d;
    end
  end

  assign bus.k_out     = k_q;
  assign bus.k_upd     = upd_q;
  assign bus.gate      = gate_q;
  assign bus.entry_idx = idx_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_freq_sel_sched.sv
// Bench for freq_sel_sched: directed scenarios followed by random traffic,
// every cycle compared against a frame-count model of the scan schedule.
module tb_freq_sel_sched;
  localparam int NE = 16;
  localparam int KW = 14;
  localparam int DW = 16;
  localparam int AW = $clog2(NE);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  freq_sel_sched_if #(.N_ENTRY(NE), .K_WIDTH(KW), .DWELL_WIDTH(DW)) bus();

  freq_sel_sched #(.N_ENTRY(NE), .K_WIDTH(KW), .DWELL_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position in the scan derived from frames seen since start.
  int mtab [NE];
  bit run;
  int f, mlen, mdwell;
  int kout_e, idx_e;
  bit upd_e, gate_e, err_e;
  int upd_log [$];
  int gate_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model();
    if (reset) begin
      run = 0; f = 0; mlen = 0; mdwell = 0;
      kout_e = 0; idx_e = 0; upd_e = 0; gate_e = 0; err_e = 0;
    end else begin
      upd_e = 0; err_e = 0;
      if (bus.stop) begin
        run = 0; gate_e = 0;
      end else if (!run) begin
        if (bus.start) begin
          if (bus.cfg_len == 0) err_e = 1;
          else begin
            run = 1; f = 0;
            mlen = int'(bus.cfg_len);
            mdwell = (bus.cfg_dwell == 0) ? 1 : int'(bus.cfg_dwell);
          end
        end
      end else if (bus.frame_sync) begin
        int t, p;
        f++;
        t = f - 1;
        p = mdwell + 1;
        if (t % p == 0) begin
          idx_e = (t / p) % mlen;
          kout_e = mtab[idx_e];
          upd_e = 1; gate_e = 0;
        end else gate_e = 1;
      end
    end
    if (bus.cfg_we) mtab[bus.cfg_addr] = int'(bus.cfg_k);
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("k_out", 32'(bus.k_out), kout_e);
    chk("k_upd", 32'(bus.k_upd), 32'(upd_e));
    chk("gate", 32'(bus.gate), 32'(gate_e));
    chk("entry_idx", 32'(bus.entry_idx), idx_e);
    chk("busy", 32'(bus.busy), 32'(run));
    chk("err", 32'(bus.err), 32'(err_e));
    if (bus.k_upd === 1'b1) upd_log.push_back(int'(bus.k_out));
    if (bus.gate === 1'b1) gate_cnt++;
    bus.start = 0; bus.stop = 0; bus.frame_sync = 0; bus.cfg_we = 0;
  endtask

  task automatic frame(input int n);
    repeat (n) begin
      bus.frame_sync = 1;
      step();
      repeat (7) step();
    end
  endtask

  task automatic wr(input int a, input int k);
    bus.cfg_we = 1;
    bus.cfg_addr = AW'(a);
    bus.cfg_k = KW'(k);
    step();
  endtask

  initial begin
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_k = '0; bus.cfg_len = '0;
    bus.cfg_dwell = '0; bus.start = 0; bus.stop = 0; bus.frame_sync = 0;
    for (int i = 0; i < NE; i++) mtab[i] = 0;

    // Reset state
    reset = 1;
    step(); step();
    reset = 0;
    chk("rst_k_out", 32'(bus.k_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);

    // Table load
    wr(0, 100); wr(1, 200); wr(2, 300);
    for (int i = 3; i < NE; i++) wr(i, int'($urandom_range(0, 16383)));

    // Start with zero length is rejected
    bus.cfg_len = '0; bus.start = 1;
    step();
    chk("len0_err", 32'(bus.err), 1);
    step();
    chk("len0_err_pulse", 32'(bus.err), 0);
    chk("len0_busy", 32'(bus.busy), 0);
    chk("len0_k_out", 32'(bus.k_out), 0);

    // Basic scan; frame_sync on the start cycle is ignored
    bus.cfg_len = 5'd3; bus.cfg_dwell = 16'd2;
    bus.start = 1; bus.frame_sync = 1;
    step();
    repeat (7) step();
    chk("no_upd_before_2nd_fs", upd_log.size(), 0);
    gate_cnt = 0;
    frame(10);
    chk("scan_upd_count", upd_log.size(), 4);
    if (upd_log.size() == 4) begin
      chk("scan_k0", upd_log[0], 100);
      chk("scan_k1", upd_log[1], 200);
      chk("scan_k2", upd_log[2], 300);
      chk("scan_k3", upd_log[3], 100);
    end
    chk("scan_gate_cycles", gate_cnt, 48);
    bus.stop = 1; step();

    // Stop mid-dwell on entry 1, then restart from entry 0
    bus.start = 1; step();
    frame(5);
    repeat (3) step();
    chk("pre_stop_gate", 32'(bus.gate), 1);
    bus.stop = 1; step();
    chk("stop_gate", 32'(bus.gate), 0);
    chk("stop_busy", 32'(bus.busy), 0);
    chk("stop_k_out", 32'(bus.k_out), 200);
    chk("stop_idx", 32'(bus.entry_idx), 1);
    upd_log.delete();
    bus.start = 1; step();
    frame(1);
    chk("restart_k_out", 32'(bus.k_out), 100);
    chk("restart_idx", 32'(bus.entry_idx), 0);

    // Live table rewrite and ignored dwell change
    wr(1, 555);
    bus.cfg_dwell = 16'd5;
    frame(3);
    chk("rewrite_upd_count", upd_log.size(), 2);
    chk("rewrite_k_out", 32'(bus.k_out), 555);
    chk("rewrite_idx", 32'(bus.entry_idx), 1);

    // Reset during settle, then restart reads table[0]
    reset = 1; step(); reset = 0;
    chk("rst_mid_k_out", 32'(bus.k_out), 0);
    chk("rst_mid_gate", 32'(bus.gate), 0);
    chk("rst_mid_busy", 32'(bus.busy), 0);
    chk("rst_mid_idx", 32'(bus.entry_idx), 0);
    bus.cfg_dwell = 16'd2; bus.start = 1; step();
    frame(1);
    chk("rst_restart_k_out", 32'(bus.k_out), 100);
    bus.stop = 1; step();

    // Random traffic against the model
    repeat (1500) begin
      reset = ($urandom_range(0, 249) == 0);
      bus.frame_sync = ($urandom_range(0, 3) == 0);
      bus.start = ($urandom_range(0, 19) == 0);
      bus.stop = ($urandom_range(0, 79) == 0);
      bus.cfg_we = ($urandom_range(0, 7) == 0);
      bus.cfg_addr = AW'($urandom_range(0, NE - 1));
      bus.cfg_k = KW'($urandom_range(0, 16383));
      bus.cfg_len = (AW + 1)'($urandom_range(0, NE));
      bus.cfg_dwell = DW'($urandom_range(0, 3));
      step();
    end
    reset = 0;
    bus.stop = 1; step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/freq_sel_sched.md
FREQ_SEL_SCHED -- requirements
Module: freq_sel_sched

Interface
- REQ-001 SHALL have parameter N_ENTRY, default 16, meaning bin-table depth (power of two).
- REQ-002 SHALL have parameter K_WIDTH, default 14, meaning bin-index width (matches selector k).
- REQ-003 SHALL have parameter DWELL_WIDTH, default 16, meaning dwell-counter width.
- REQ-004 SHALL have port clk, input, 1, meaning sole clock; all logic rising-edge.
- REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
- REQ-006 SHALL have port cfg_we, input, 1, meaning table write strobe.
- REQ-007 SHALL have port cfg_addr, input, log2(N_ENTRY), meaning table write address.
- REQ-008 SHALL have port cfg_k, input, K_WIDTH, meaning bin index to write.
- REQ-009 SHALL have port cfg_len, input, log2(N_ENTRY)+1, meaning active entry count, 0..N_ENTRY.
- REQ-010 SHALL have port cfg_dwell, input, DWELL_WIDTH, meaning gated frames per entry.
- REQ-011 SHALL have ports start and stop, input, 1 each, meaning single-cycle run and halt commands.
- REQ-012 SHALL have port frame_sync, input, 1, meaning single-cycle pulse at each upstream frame boundary.
- REQ-013 SHALL have port k_out, output, K_WIDTH, meaning bin index driven to the frequency selector k input.
- REQ-014 SHALL have port k_upd, output, 1, meaning one-cycle pulse when k_out changes.
- REQ-015 SHALL have port gate, output, 1, meaning downstream valid qualifier; data accepted only while high.
- REQ-016 SHALL have ports entry_idx (output, log2(N_ENTRY), current table index), busy (output, 1, state not IDLE), and err (output, 1, one-cycle pulse on rejected start).

Function
- REQ-017 SHALL implement table writes on any cfg_we cycle, in any state, taking effect on the next read of that entry.
- REQ-018 SHALL latch cfg_len and cfg_dwell on an accepted start; later changes SHALL NOT affect the running scan; a cfg_dwell of 0 SHALL be treated as 1.
- REQ-019 SHALL implement FSM states IDLE, ARM, SWITCH-SETTLE (SETTLE), and DWELL.
- REQ-020 SHALL move from IDLE to ARM on start when cfg_len != 0; a start with cfg_len == 0 SHALL leave the FSM in IDLE and pulse err for 1 cycle.
- REQ-021 SHALL ignore a frame_sync coincident with the start cycle; ARM waits for a later frame_sync.
- REQ-022 SHALL, on frame_sync in ARM, set entry_idx=0 and move to SETTLE; in the following cycle k_out=table[0], k_upd=1, and gate=0.
- REQ-023 SHALL, in SETTLE, hold gate=0 for one full frame; on the next frame_sync, move to DWELL, set gate=1 from the following cycle, and clear the frame counter to 0.
- REQ-024 SHALL, in DWELL, increment the frame counter on each frame_sync; when the count reaches the latched dwell, the same frame_sync SHALL advance entry_idx, load k_out, pulse k_upd, drive gate=0 next cycle, and move to SETTLE.
- REQ-025 SHALL wrap entry_idx from len-1 to 0 and scan continuously until stop.
- REQ-026 SHALL give each entry exactly dwell+1 frames: 1 settle frame plus dwell gated frames.
- REQ-027 SHALL treat len=1 as valid: k_upd still pulses each period, k_out value is unchanged, and the settle frame still applies.
- REQ-028 SHALL, on stop in any state, go to IDLE next cycle with gate=0 and busy=0, while k_out and entry_idx hold their values; stop coincident with start SHALL win (the FSM stays IDLE).
- REQ-029 SHALL ignore start while busy.
- REQ-030 SHALL NOT let frame_sync in IDLE change any output.

Reset
- REQ-031 SHALL, on reset, set state=IDLE, k_out=0, k_upd=0, gate=0, entry_idx=0, busy=0, err=0, the frame counter to 0, and the latched len/dwell to 0.
- REQ-032 SHALL leave table contents unchanged on reset; contents are undefined until written.
- REQ-033 SHALL give reset priority over all inputs; reset mid-scan SHALL abort to IDLE in the next cycle.

Verification
- REQ-034 SHALL be verified by: write table {100,200,300}, len=3, dwell=2, start, frame_sync every 8 cycles -> k_out 100,200,300,100 with each entry held 3 frames, gate high 2 frames of each 3, k_upd once per entry.
- REQ-035 SHALL be verified by: len=0 then start -> err 1-cycle pulse, busy stays 0, k_out stays 0.
- REQ-036 SHALL be verified by: stop asserted mid-DWELL on entry 1 -> next cycle gate=0, busy=0, k_out=200 held; a restart begins again at entry 0.
- REQ-037 SHALL be verified by: start and frame_sync in the same cycle -> no k_upd until the second frame_sync.
- REQ-038 SHALL be verified by: rewriting table[1]=555 while running on entry 0 -> the next switch outputs 555; changing cfg_dwell to 5 mid-run -> dwell stays 2.
- REQ-039 SHALL be verified by: reset asserted during SETTLE -> all outputs 0 next cycle, and table[0] readback after restart = 100.
